// File: rtl/gpio_in_cond.sv
// gpio_in_cond: input conditioning for the GPIO pins.
//
// Each raw pin bit is synchronised (two flops), then debounced by a per-bit
// 8-bit counter: a new level is accepted only after DEB_CYC consecutive
// sampled cycles that differ from the current stable level. The stable
// vector drives gpio_in. Rising edges of the stable level set sticky RISE
// flags; a masked OR of the flags drives irq. Flags and mask sit on the
// data-memory bus.
//
// Optional feature macro: GPIO_FALL_EDGE_EN adds sticky FALL flags at 0x04
// that also feed irq. Without it, 0x04 is unmapped.
//
// Parameters:
//   DW       data/pin width
//   AW       bus address width
//   DEB_CYC  stable sampled cycles needed to accept a new level (1..255)
//
// Ports:
//   clk      clock, all state on rising edge
//   rst      asynchronous active-high reset
//   pin_in   raw asynchronous pin levels
//   gpio_in  debounced levels
//   din      bus write data
//   addr     bus address
//   we       bus write enable (1 = write)
//   dout     registered bus read data
//   irq      level interrupt request
//
// Register map:
//   0x02 RISE  read flags, write-1-clear
//   0x03 IEN   read/write interrupt mask
//   0x04 FALL  (GPIO_FALL_EDGE_EN only) read flags, write-1-clear

module gpio_in_cond #(
    parameter int unsigned DW      = 16,
    parameter int unsigned AW      = 13,
    parameter int unsigned DEB_CYC = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [DW-1:0] pin_in,
    output logic [DW-1:0] gpio_in,
    input  logic [DW-1:0] din,
    input  logic [AW-1:0] addr,
    input  logic          we,
    output logic [DW-1:0] dout,
    output logic          irq
);

    localparam logic [AW-1:0] ADDR_RISE = AW'(2);
    localparam logic [AW-1:0] ADDR_IEN  = AW'(3);
`ifdef GPIO_FALL_EDGE_EN
    localparam logic [AW-1:0] ADDR_FALL = AW'(4);
`endif
    localparam logic [7:0]    CNT_MAX   = 8'(DEB_CYC - 1);

    logic [DW-1:0]      s1_q, s2_q;
    logic [DW-1:0]      st_q, st_d;
    // Stable level one cycle late; edges of st are flagged one edge after st moves.
    logic [DW-1:0]      st_dly_q;
    logic [DW-1:0][7:0] cnt_q, cnt_d;
    logic [DW-1:0]      rise_q, rise_d;
    logic [DW-1:0]      ien_q, ien_d;
    logic [DW-1:0]      dout_q, dout_d;
    logic [DW-1:0]      rise_clr;
`ifdef GPIO_FALL_EDGE_EN
    logic [DW-1:0]      fall_q, fall_d;
    logic [DW-1:0]      fall_clr;
`endif

    // Per-bit debounce: any sample matching the stable level restarts the count.
    always_comb begin
        st_d  = st_q;
        cnt_d = cnt_q;
        for (int i = 0; i < int'(DW); i++) begin
            if (s2_q[i] == st_q[i]) begin
                cnt_d[i] = 8'd0;
            end else if (cnt_q[i] == CNT_MAX) begin
                st_d[i]  = s2_q[i];
                cnt_d[i] = 8'd0;
            end else begin
                cnt_d[i] = cnt_q[i] + 8'd1;
            end
        end
    end

    // Flag set term is ORed in after the clear, so a coincident set wins.
    always_comb begin
        rise_clr = (we && addr == ADDR_RISE) ? din : '0;
        rise_d   = (rise_q & ~rise_clr) | (st_q & ~st_dly_q);
        ien_d    = (we && addr == ADDR_IEN) ? din : ien_q;
    end

`ifdef GPIO_FALL_EDGE_EN
    always_comb begin
        fall_clr = (we && addr == ADDR_FALL) ? din : '0;
        fall_d   = (fall_q & ~fall_clr) | (~st_q & st_dly_q);
    end
`endif

    // Reads sample register contents before any same-edge update.
    always_comb begin
        dout_d = dout_q;
        if (!we) begin
            case (addr)
                ADDR_RISE: dout_d = rise_q;
                ADDR_IEN:  dout_d = ien_q;
`ifdef GPIO_FALL_EDGE_EN
                ADDR_FALL: dout_d = fall_q;
`endif
                default:   dout_d = dout_q;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_q     <= '0;
            s2_q     <= '0;
            st_q     <= '0;
            st_dly_q <= '0;
            cnt_q    <= '0;
            rise_q   <= '0;
            ien_q    <= '0;
            dout_q   <= '0;
        end else begin
            s1_q     <= pin_in;
            s2_q     <= s1_q;
            st_q     <= st_d;
            st_dly_q <= st_q;
            cnt_q    <= cnt_d;
            rise_q   <= rise_d;
            ien_q    <= ien_d;
            dout_q   <= dout_d;
        end
    end

`ifdef GPIO_FALL_EDGE_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fall_q <= '0;
        end else begin
            fall_q <= fall_d;
        end
    end
`endif

    assign gpio_in = st_q;
    assign dout    = dout_q;
`ifdef GPIO_FALL_EDGE_EN
    assign irq     = |((rise_q | fall_q) & ien_q);
`else
    assign irq     = |(rise_q & ien_q);
`endif

endmodule

// File: tb/tb_gpio_in_cond.sv
// tb_gpio_in_cond: directed and random stimulus for gpio_in_cond, checked
// against a behavioural model built from run lengths of the synchronised
// pin samples. Honours GPIO_FALL_EDGE_EN when defined.

module tb_gpio_in_cond;

    localparam int DW = 16;
    localparam int AW = 13;
    localparam int D  = 16;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic [DW-1:0] pin_in = '0;
    logic [DW-1:0] gpio_in;
    logic [DW-1:0] din = '0;
    logic [AW-1:0] addr = '0;
    logic          we = 1'b0;
    logic [DW-1:0] dout;
    logic          irq;

    int vectors     = 0;
    int miscompares = 0;

    gpio_in_cond #(.DW(DW), .AW(AW), .DEB_CYC(D)) dut (
        .clk     (clk),
        .rst     (rst),
        .pin_in  (pin_in),
        .gpio_in (gpio_in),
        .din     (din),
        .addr    (addr),
        .we      (we),
        .dout    (dout),
        .irq     (irq)
    );

    always #5 clk = ~clk;

    // Model: pins seen two edges late; a bit flips when its sampled value has
    // differed from the stable level for D samples in a row.
    logic [DW-1:0] m_p1, m_p2, m_st, m_rose, m_fell, m_rise, m_fall, m_ien, m_dout, m_rv;
    int            m_run [DW];

    task automatic model_clear();
        m_p1 = '0; m_p2 = '0; m_st = '0; m_rose = '0; m_fell = '0;
        m_rise = '0; m_fall = '0; m_ien = '0; m_dout = '0; m_rv = '0;
        for (int i = 0; i < DW; i++) m_run[i] = 0;
    endtask

    task automatic model_edge();
        logic [DW-1:0] st_new;
        logic [DW-1:0] clr;
        for (int i = 0; i < DW; i++) begin
            if (m_p2[i] == m_rv[i]) m_run[i] = m_run[i] + 1;
            else begin
                m_rv[i]  = m_p2[i];
                m_run[i] = 1;
            end
            st_new[i] = (m_p2[i] != m_st[i] && m_run[i] >= D) ? m_p2[i] : m_st[i];
        end
        if (!we) begin
            if (addr == 13'd2) m_dout = m_rise;
            else if (addr == 13'd3) m_dout = m_ien;
`ifdef GPIO_FALL_EDGE_EN
            else if (addr == 13'd4) m_dout = m_fall;
`endif
        end
        clr    = (we && addr == 13'd2) ? din : '0;
        m_rise = (m_rise & ~clr) | m_rose;
`ifdef GPIO_FALL_EDGE_EN
        clr    = (we && addr == 13'd4) ? din : '0;
        m_fall = (m_fall & ~clr) | m_fell;
`endif
        if (we && addr == 13'd3) m_ien = din;
        m_rose = st_new & ~m_st;
        m_fell = ~st_new & m_st;
        m_st   = st_new;
        m_p2   = m_p1;
        m_p1   = pin_in;
    endtask

    task automatic chk(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        vectors++;
        assert (got === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        model_edge();
        @(posedge clk);
        #1;
        chk("gpio_in", gpio_in, m_st);
        chk("irq", {15'd0, irq}, {15'd0, |((m_rise | m_fall) & m_ien)});
        chk("dout", dout, m_dout);
    endtask

    task automatic do_reset(input logic [DW-1:0] pins);
        pin_in = pins; we = 1'b0; addr = '0; din = '0;
        rst = 1'b1;
        #2;
        chk("rst_gpio_in", gpio_in, 16'h0000);
        chk("rst_irq", {15'd0, irq}, 16'h0000);
        chk("rst_dout", dout, 16'h0000);
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_clear();
    endtask

    task automatic bus_write(input logic [AW-1:0] a, input logic [DW-1:0] d);
        we = 1'b1; addr = a; din = d;
        step();
        we = 1'b0; addr = '0; din = '0;
    endtask

    initial begin
        int n;
        int first;
        logic hi;
        model_clear();
        #1;

        // Reset with all pins high, then full re-qualification latency.
        do_reset(16'hFFFF);
        repeat (D + 1) step();
        chk("rst_lat_early", gpio_in, 16'h0000);
        step();
        chk("rst_lat", gpio_in, 16'hFFFF);
        step();
        addr = 13'd2;
        step();
        chk("rise_after_rst", dout, 16'hFFFF);

        // Short glitch on bit 3 is rejected.
        do_reset(16'h0000);
        hi = 1'b0;
        pin_in[3] = 1'b1;
        repeat (10) begin step(); hi |= gpio_in[3]; end
        pin_in[3] = 1'b0;
        repeat (30) begin step(); hi |= gpio_in[3]; end
        chk("glitch_gpio", {15'd0, hi}, 16'h0000);
        addr = 13'd2;
        step();
        chk("glitch_rise", dout, 16'h0000);

        // 20-cycle pulse passes with exact width and 18-edge delay.
        pin_in[3] = 1'b1;
        n = 0; first = -1;
        for (int k = 1; k <= 60; k++) begin
            step();
            if (gpio_in[3]) begin
                n++;
                if (first < 0) first = k;
            end
            if (k == 20) pin_in[3] = 1'b0;
        end
        chk("pulse_len", 16'(n), 16'd20);
        chk("pulse_start", 16'(first), 16'(D + 2));
        bus_write(13'd2, 16'hFFFF);

        // Interrupt on bit 2, then clear.
        bus_write(13'd3, 16'h0004);
        pin_in[2] = 1'b1;
        repeat (D + 2) step();
        chk("irq_early", {15'd0, irq}, 16'h0000);
        step();
        chk("irq_set", {15'd0, irq}, 16'h0001);
        bus_write(13'd2, 16'h0004);
        chk("irq_clr", {15'd0, irq}, 16'h0000);
        addr = 13'd2;
        step();
        chk("rise_clr", dout, 16'h0000);

        // Clear and set of RISE[5] on the same edge: set wins.
        addr = '0;
        pin_in[5] = 1'b1;
        repeat (D + 2) step();
        bus_write(13'd2, 16'h0020);
        addr = 13'd2;
        step();
        chk("set_wins", dout, 16'h0020);

        // Reset mid-debounce discards the count.
        addr = '0;
        pin_in[7] = 1'b1;
        repeat (12) step();
        do_reset(pin_in);
        repeat (D + 1) step();
        chk("rst_mid_early", gpio_in, 16'h0000);
        step();
        chk("rst_mid", gpio_in, 16'h00A4);

        // Unmapped address holds dout.
        bus_write(13'd3, 16'h1234);
        addr = 13'd3;
        step();
        bus_write(13'd7, 16'hFFFF);
        addr = 13'd7;
        step();
        chk("unmapped_hold", dout, 16'h1234);
`ifdef GPIO_FALL_EDGE_EN
        bus_write(13'd3, 16'h0001);
        pin_in[0] = 1'b1;
        repeat (D + 4) step();
        bus_write(13'd2, 16'hFFFF);
        pin_in[0] = 1'b0;
        repeat (D + 3) step();
        chk("fall_irq", {15'd0, irq}, 16'h0001);
        addr = 13'd4;
        step();
        chk("fall_read", dout, 16'h0001);
`else
        addr = 13'd4;
        step();
        chk("addr4_hold", dout, 16'h1234);
`endif

        // Random pins and bus traffic against the model.
        addr = '0;
        for (int t = 0; t < 3000; t++) begin
            for (int i = 0; i < DW; i++) begin
                if ($urandom_range(23, 0) == 0) pin_in[i] = ~pin_in[i];
            end
            we   = ($urandom_range(3, 0) == 0);
            addr = 13'($urandom_range(7, 0));
            din  = 16'($urandom);
            step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/gpio_in_cond.md
# gpio_in_cond

Input conditioning stage between the GPIO input pins and the GPIO register block's `gpio_in` port. Synchronises each raw pin bit, debounces it with a per-bit counter and drives the clean vector downstream. Also latches rising edges (optionally falling edges) into sticky flag registers and raises a maskable interrupt. The flags and the mask are visible on the same data-memory bus as the other I/O registers.

## Interface
- `DW`, 16, data/pin width.
- `AW`, 13, bus address width.
- `DEB_CYC`, 16, consecutive stable cycles required to accept a new level; legal range 1..255.
- `clk`  in  1  single clock; all state on rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `pin_in`  in  DW  raw asynchronous pin levels.
- `gpio_in`  out  DW  debounced levels; feeds the GPIO register block's `gpio_in`.
- `din`  in  DW  bus write data.
- `addr`  in  AW  bus address.
- `we`  in  1  bus write enable, high = write.
- `dout`  out  DW  registered bus read data.
- `irq`  out  1  interrupt request, level, high = pending.

## Operation
- Synchroniser: 2 flops per bit (`s1`, `s2`), reset 0.
- Debounce, per bit i, counter `cnt[i]` (8 bits), stable level `st[i]`:
  - if `s2[i] == st[i]`: `cnt[i] <= 0`.
  - else if `cnt[i] == DEB_CYC-1`: `st[i] <= s2[i]`, `cnt[i] <= 0`.
  - else `cnt[i] <= cnt[i]+1`.
  - A glitch shorter than `DEB_CYC` sampled cycles resets the count; `st` is unchanged.
- `gpio_in = st`.
- Rise flags `RISE[i]`: set on the cycle `st[i]` goes 0->1, sticky.
- Register map:
  - 0x02 RISE: read returns flags. Write: each bit with `din[i]=1` clears `RISE[i]`.
  - 0x03 IEN: read/write interrupt mask.
  - 0x04 FALL: only with the macro enabled; see Configuration.
- Writes to any other address are ignored.
- Simultaneous set and write-1-clear of the same flag bit: the set wins, so the flag stays 1.
- `irq = |(RISE & IEN)` (OR the FALL term when enabled). It is driven combinationally from registers, with no extra register stage.
- Bus reads:
  - On a rising edge with `we=0` and a mapped address, `dout` loads that register's current value.
  - Unmapped addresses, and cycles with `we=1`, leave `dout` holding its previous value.
- Reset values: `s1`, `s2`, `st`, `cnt`, RISE, FALL, IEN, `dout` all 0. Hence `gpio_in=0`, `irq=0`, `dout=0`.
- An asserted `rst` in mid-debounce discards the count. After release, a pin already high is re-qualified from zero: it takes the full latency and then sets RISE.

## Timing
- Pin step captured at edge E1 (`s1`), E2 (`s2`). `cnt` increments at E3..E(DEB_CYC+1). `st`/`gpio_in` change at edge E(DEB_CYC+2).
- With `DEB_CYC=1`, `gpio_in` changes at E3.
- RISE bit set at the edge after `st` rises: E(DEB_CYC+3). `irq` rises combinationally after that edge if IEN bit is set.
- Read latency: 1 cycle. `dout` is valid after the edge that samples `addr`, matching the GPIO register block.
- Write latency: a flag clear or IEN update is visible one edge after the write. `irq` drops after the same edge.

## Configuration
- `GPIO_FALL_EDGE_EN` defined:
  - FALL register at 0x04: `FALL[i]` is set on `st[i]` 1->0, with the same sticky, write-1-clear and set-wins rules as RISE.
  - FALL participates in `irq`: `irq = |((RISE|FALL) & IEN)`.
- `GPIO_FALL_EDGE_EN` undefined:
  - No FALL storage.
  - Address 0x04 is unmapped: reads hold `dout`, writes are ignored.
  - `irq = |(RISE & IEN)`.

## Test plan
- Reset with `pin_in=16'hFFFF` held -> `gpio_in=0`, `irq=0`, `dout=0` during reset. After release, `gpio_in=16'hFFFF` exactly `DEB_CYC+2` edges later and RISE reads 16'hFFFF.
- DEB_CYC=16, bit 3 pulses high for 10 cycles -> `gpio_in[3]` stays 0 and RISE reads 0. A 20-cycle pulse -> `gpio_in[3]` high for exactly 20 cycles after the 18-edge delay.
- Write IEN=16'h0004, then bit 2 rises -> `irq=1` at E(DEB_CYC+3). Write 0x02 with `din=16'h0004` -> `irq=0` one edge later and RISE reads 0.
- Write-1-clear of bit 5 on the same edge that RISE[5] sets -> RISE reads 16'h0020 afterwards.
- Assert `rst` when `cnt=10` on a changing bit -> after release the change needs a full `DEB_CYC+2` edges. Read of unmapped 0x07 leaves `dout` unchanged.
- With `GPIO_FALL_EDGE_EN`: bit 0 high then low, IEN=1 -> FALL reads 16'h0001 and `irq=1`. Without the macro, reading 0x04 holds the prior `dout`.
